// File: rtl/mips_program_loader.sv
// mips_program_loader: boot loader that streams a header plus big-endian words into MIPS unified memory
// Ports: clk/rst (async active-low) | start begins a session | rx_valid/rx_data/rx_ready byte stream handshake
//        mem_we/mem_addr/mem_wdata memory write port | cpu_rst core reset | busy/done/err session status
module mips_program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, HDR_BASE, HDR_CNT, DATA, WRITE, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [31:0]       r_base, r_cnt;
  logic [23:0]       r_shift;
  logic [1:0]        r_bcnt;
  logic [ADDR_W-1:0] r_idx;
  logic              w_acc, w_last_byte, w_last_word, w_start;
  logic [31:0]       w_cnt_full;
  logic [32:0]       w_end;
  assign w_acc       = rx_valid && rx_ready;
  assign w_last_byte = w_acc && (r_bcnt == 2'd3);
  assign w_start     = start && (r_state inside {IDLE, DONE, ERR});
  assign w_cnt_full  = {r_cnt[23:0], rx_data};
  // 33-bit sum so a huge BASE+COUNT cannot wrap past the check
  assign w_end       = {1'b0, r_base} + {1'b0, w_cnt_full};
  assign w_last_word = {{(32-ADDR_W){1'b0}}, r_idx} == (r_cnt - 32'd1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: w_next = w_start ? HDR_BASE : r_state;
      HDR_BASE:        w_next = w_last_byte ? HDR_CNT : r_state;
      HDR_CNT:         w_next = !w_last_byte ? r_state :
                                (w_end > (33'd1 << ADDR_W)) ? ERR :
                                (w_cnt_full == 32'd0) ? DONE : DATA;
      DATA:            w_next = w_last_byte ? WRITE : r_state;
      WRITE:           w_next = w_last_word ? DONE : DATA;
      default:         w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  // Outputs are registered by decoding the next state, so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base    <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_idx     <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (w_start) begin
        r_bcnt <= '0;
        r_idx  <= '0;
      end
      if (w_acc) r_bcnt <= r_bcnt + 2'd1;
      if (w_acc && r_state == HDR_BASE) r_base <= {r_base[23:0], rx_data};
      if (w_acc && r_state == HDR_CNT) r_cnt <= w_cnt_full;
      if (w_acc && r_state == DATA) r_shift <= {r_shift[15:0], rx_data};
      if (w_last_byte && r_state == DATA) begin
        mem_addr  <= r_base[ADDR_W-1:0] + r_idx;
        mem_wdata <= {r_shift, rx_data};
      end
      if (r_state == WRITE) r_idx <= r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
      rx_ready <= w_next inside {HDR_BASE, HDR_CNT, DATA};
      mem_we   <= w_next == WRITE;
      cpu_rst  <= w_next != DONE;
      busy     <= !(w_next inside {IDLE, DONE, ERR});
      done     <= w_next == DONE;
      err      <= w_next == ERR;
    end
  end
endmodule

// File: tb/tb_mips_program_loader.sv
// tb_mips_program_loader: scoreboard bench for the byte-stream program loader
module tb_mips_program_loader;
  localparam int AW = 10;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, mem_we, cpu_rst, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [41:0]   sb[$];
  logic [31:0]   wbuf[0:31];
  mips_program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [41:0] e;
    if (rst && mem_we) begin
      chk("we_rx_ready", {63'd0, rx_ready}, 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("waddr", {54'd0, mem_addr}, {54'd0, e[41:32]});
        chk("wdata", {32'd0, mem_wdata}, {32'd0, e[31:0]});
      end else chk("unexpected_we", {63'd0, mem_we}, 64'd0);
    end
  end
  task automatic send_byte(input logic [7:0] b, input bit bp);
    if (bp) repeat ($urandom_range(0, 3)) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 20 && !rx_ready; t++) @(negedge clk);
    if (!rx_ready) chk("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit bp);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], bp);
  endtask
  task automatic load(input logic [31:0] base, input logic [31:0] cnt, input int nw,
                      input bit bp, input bit ign, input bit exp_done);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_rx_ready", {63'd0, rx_ready}, 64'd1);
    chk("start_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("start_flags", {62'd0, done, err}, 64'd0);
    send_word(base, bp);
    send_word(cnt, bp);
    for (int i = 0; i < nw; i++) begin
      sb.push_back({base[AW-1:0] + AW'(i), wbuf[i]});
      send_word(wbuf[i], bp);
      if (ign && i == 0) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", {63'd0, busy}, 64'd1);
        chk("ign_rx_ready", {63'd0, rx_ready}, 64'd1);
      end
    end
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    chk("end_busy", {63'd0, busy}, 64'd0);
    chk("end_done", {63'd0, done}, {63'd0, exp_done});
    chk("end_err", {63'd0, err}, {63'd0, !exp_done});
    chk("end_cpu_rst", {63'd0, cpu_rst}, {63'd0, !exp_done});
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
    wbuf[0]  = 32'h20190200;
    wbuf[3]  = 32'h8F37000F;
    wbuf[20] = 32'h1000FFFF;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_outs", {54'd0, rx_ready, mem_we, busy, done, err, 5'd0}, 64'd0);
    chk("rst_bus", {22'd0, mem_addr, mem_wdata}, 64'd0);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    repeat (4) @(negedge clk);
    chk("idle_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    // start arrives while a junk byte is offered; that byte must not be taken as header
    load(32'd0, 32'd21, 21, 1'b0, 1'b0, 1'b1);
    rx_valid = 1'b1;
    rx_data = 8'h77;
    wbuf[0] = 32'h00000005;
    load(32'd527, 32'd1, 1, 1'b0, 1'b0, 1'b1);
    wbuf[0] = 32'h20190200;
    load(32'd0, 32'd21, 21, 1'b1, 1'b0, 1'b1);
    load(32'd1020, 32'd5, 0, 1'b0, 1'b0, 1'b0);
    load(32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b1);
    load(32'd1020, 32'd4, 4, 1'b1, 1'b0, 1'b1);
    load(32'd100, 32'd3, 3, 1'b0, 1'b1, 1'b1);
    // asynchronous reset in the middle of a data word
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'd0, 1'b0);
    send_word(32'd21, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("mid_rst_outs", {59'd0, rx_ready, mem_we, busy, done, err}, 64'd0);
    chk("mid_rst_bus", {22'd0, mem_addr, mem_wdata}, 64'd0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    rx_valid = 1'b0;
    load(32'd527, 32'd1, 1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_program_loader.md
# mips_program_loader

Upstream boot stage for the multicycle MIPS core. It accepts a byte stream carrying a load header and program/data words, assembles big-endian 32-bit words, and writes them into the core's unified memory through a dedicated write port. It holds the core in reset during loading and releases it only after a clean load. This replaces hierarchical memory pokes as the way to get code and data (e.g. the Fibonacci input at word 527) into the machine.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the unified memory (depth 2^ADDR_W words)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a load session; ignored while busy
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts the byte this cycle; transfer occurs when rx_valid && rx_ready at a rising edge
- mem_we  out  1  memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address for the write
- mem_wdata  out  32  word to write
- cpu_rst  out  1  active-high reset to the MIPS core
- busy  out  1  session in progress
- done  out  1  last session completed cleanly; sticky until the next accepted start
- err  out  1  last session aborted on a bad header; sticky until the next accepted start

## Operation
- Stream format:
  - 4 bytes: BASE, word address.
  - 4 bytes: COUNT, number of words.
  - COUNT×4 bytes of data.
  - All fields are big-endian: the first byte is bits 31:24.
- States: IDLE, HDR_BASE, HDR_CNT, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start → HDR_BASE:
  - clear done and err; clear the byte counter and word index.
  - assert cpu_rst.
- HDR_BASE: accept 4 bytes into BASE → HDR_CNT.
- HDR_CNT: accept 4 bytes into COUNT. Evaluate the header on the 4th byte using 33-bit arithmetic:
  - BASE + COUNT > 2^ADDR_W → ERR.
  - COUNT == 0 → DONE.
  - otherwise → DATA.
- DATA: accept 4 bytes into a shift register → WRITE.
- WRITE, single cycle:
  - mem_we=1, mem_addr = BASE[ADDR_W-1:0] + idx, mem_wdata = assembled word.
  - If idx == COUNT-1 → DONE; else idx++ → DATA.
- DONE: cpu_rst=0, done=1, busy=0.
- ERR: cpu_rst stays 1, err=1, busy=0.
- rx_ready=1 only in HDR_BASE, HDR_CNT and DATA; 0 in IDLE, WRITE, DONE and ERR.
- start is honoured only in IDLE, DONE or ERR.
  - A start in DONE re-asserts cpu_rst, so reloading a running core is legal.
- Bytes presented while rx_ready=0 are not consumed. The upstream source holds them.
- No address wrap: the header check guarantees BASE+idx < 2^ADDR_W.

## Timing
- Reset values (rst low, applied asynchronously):
  - state=IDLE
  - cpu_rst=1
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, done=0, err=0
- All outputs are registered.
- start sampled at edge N:
  - busy=1 and rx_ready=1 from edge N; the first header byte can transfer at edge N+1.
- Word write timing:
  - The 4th byte of a data word transfers at edge T.
  - mem_we=1 during cycle T..T+1. The memory captures the word at edge T+1.
  - rx_ready returns to 1 after edge T+1.
- Throughput: with rx_valid held high, a word costs 5 cycles.
- DONE timing:
  - For the last data word, cpu_rst falls at the same edge as its write (edge T+1); the write lands in memory at that edge.
  - For the COUNT==0 path, cpu_rst falls at the edge after the last header byte.
- Reset asserted mid-session: the loader returns to IDLE immediately with cpu_rst=1. Partially loaded memory is left as-is.
- start and a byte in the same cycle while in IDLE: the byte is not consumed (rx_ready=0).

## Test plan
- Reset: drive rst=0 mid-stream → cpu_rst=1, all other outputs 0. Release rst → IDLE; bytes are not consumed until start.
- Program load: start, then BASE=0, COUNT=21, then the words 0x20190200 … 0x1000FFFF.
  - Expect 21 mem_we pulses at addresses 0..20 with matching data.
  - word 3 = 0x8F37000F.
  - done=1 and cpu_rst=0 after the last write.
- Data poke: second session with BASE=527, COUNT=1, data 0x00000005.
  - Expect one write at address 527 with data 5.
  - cpu_rst pulses high during the session, then falls.
- Backpressure: drop rx_valid randomly for 0–3 cycles between bytes.
  - Same writes as the program load; no byte lost or duplicated.
  - rx_ready=0 in every WRITE cycle.
- Bad header: BASE=1020, COUNT=5 with ADDR_W=10.
  - Expect ERR: err=1, cpu_rst=1, no mem_we.
  - A later start with COUNT=0 → done=1, err=0, no writes.
- Ignored start: pulse start during DATA → no state change; the load completes normally.
